// File: rtl/ivector_initiator.sv
// IVector traffic initiator: issues say(meth,v) requests, checks heard(meth,v) indications in order.
// Optional watchdog with a timeout output when IVECTOR_INITIATOR_TIMEOUT_EN is defined.
module ivector_initiator #(
  parameter int METH_WIDTH = 6,
  parameter int V_WIDTH    = 4,
  parameter int MAX_OUT    = 4,
  parameter int SEED       = 0
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          start,
  input  logic [8:0]                    count,
  output logic                          say__ENA,
  output logic [METH_WIDTH-1:0]         say_meth,
  output logic [V_WIDTH-1:0]            say_v,
  input  logic                          say__RDY,
  input  logic                          heard__ENA,
  input  logic [METH_WIDTH-1:0]         heard_meth,
  input  logic [V_WIDTH-1:0]            heard_v,
  output logic                          heard__RDY,
  output logic                          busy,
  output logic                          done,
  output logic [8:0]                    err_count,
  output logic [METH_WIDTH+V_WIDTH-1:0] first_err
`ifdef IVECTOR_INITIATOR_TIMEOUT_EN
  ,
  output logic                          timeout
`endif
);

  localparam logic [3:0] MAX_OUT_L = 4'(MAX_OUT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                        state, state_nxt;
  logic [8:0]                    tx_idx, rx_idx, rx_nxt, total;
  logic [3:0]                    outst;
  logic [8:0]                    err_q;
  logic [METH_WIDTH+V_WIDTH-1:0] first_err_q;
  logic                          send, accept, mismatch, start_ok, active;

  function automatic logic [METH_WIDTH-1:0] meth_of(input logic [8:0] i);
    return METH_WIDTH'(i) + METH_WIDTH'(SEED);
  endfunction

  function automatic logic [V_WIDTH-1:0] v_of(input logic [8:0] i);
    return V_WIDTH'(i);
  endfunction

  function automatic logic [8:0] sat_inc9(input logic [8:0] x);
    return (x == 9'd511) ? x : x + 9'd1;
  endfunction

`ifdef IVECTOR_INITIATOR_TIMEOUT_EN
  logic [11:0] wdog;
  logic        timeout_q;
  logic        wdog_exp;
  assign wdog_exp = (wdog == 12'hFFF);
  assign timeout  = timeout_q;
`endif

  assign active     = (state == S_RUN) || (state == S_DRAIN);
  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
  assign send       = (state == S_RUN) && (tx_idx < total) && (outst < MAX_OUT_L) && say__RDY;
  assign accept     = heard__ENA && heard__RDY;
  assign mismatch   = accept && ({heard_meth, heard_v} != {meth_of(rx_idx), v_of(rx_idx)});
  assign rx_nxt     = accept ? rx_idx + 9'd1 : rx_idx;

  // Request fields are held at zero whenever no request is offered.
  assign say__ENA   = send;
  assign say_meth   = send ? meth_of(tx_idx) : '0;
  assign say_v      = send ? v_of(tx_idx) : '0;
  assign heard__RDY = active;
  assign busy       = active;
  assign done       = (state == S_DONE);
  assign err_count  = err_q;
  assign first_err  = first_err_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (total == 9'd0)           state_nxt = S_DONE;
        else if (tx_idx == total)    state_nxt = (rx_nxt == total) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: if (rx_nxt == total) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
`ifdef IVECTOR_INITIATOR_TIMEOUT_EN
    if (active && wdog_exp && !send && !accept) state_nxt = S_DONE;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      tx_idx      <= '0;
      rx_idx      <= '0;
      total       <= '0;
      outst       <= '0;
      err_q       <= '0;
      first_err_q <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        tx_idx      <= '0;
        rx_idx      <= '0;
        total       <= count;
        outst       <= '0;
        err_q       <= '0;
        first_err_q <= '0;
      end else begin
        if (send)   tx_idx <= tx_idx + 9'd1;
        if (accept) rx_idx <= rx_idx + 9'd1;
        if (send && !accept)                        outst <= outst + 4'd1;
        else if (!send && accept && outst != 4'd0) outst <= outst - 4'd1;
        if (mismatch) begin
          err_q <= sat_inc9(err_q);
          if (err_q == 9'd0) first_err_q <= {heard_meth, heard_v};
        end
      end
    end
  end

`ifdef IVECTOR_INITIATOR_TIMEOUT_EN
  // Watchdog counts consecutive active cycles with neither a send nor an accept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else if (start_ok) begin
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else if (active) begin
      if (send || accept) begin
        wdog <= '0;
      end else if (wdog_exp) begin
        wdog      <= '0;
        timeout_q <= 1'b1;
      end else begin
        wdog <= wdog + 12'd1;
      end
    end else begin
      wdog <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_ivector_initiator.sv
// Directed bench for ivector_initiator with a behavioural echo server (hold-off and corruption hooks).
module tb_ivector_initiator;
  logic       CLK = 1'b0;
  logic       RST, start, say__RDY, heard__ENA, heard__RDY;
  logic [8:0] count, err_count;
  logic       say__ENA, busy, done;
  logic [5:0] say_meth, heard_meth;
  logic [3:0] say_v, heard_v;
  logic [9:0] first_err;
`ifdef IVECTOR_INITIATOR_TIMEOUT_EN
  logic       timeout;
`endif

  int checks = 0;
  int errors = 0;
  int snd_total = 0;
  int base = 0;
  int corrupt_at = -1;
  logic hold = 1'b0;
  logic [9:0] q[$];
  logic [5:0] log_m[0:255];
  logic [3:0] log_v[0:255];

  ivector_initiator dut (
    .CLK(CLK), .RST(RST), .start(start), .count(count),
    .say__ENA(say__ENA), .say_meth(say_meth), .say_v(say_v), .say__RDY(say__RDY),
    .heard__ENA(heard__ENA), .heard_meth(heard_meth), .heard_v(heard_v), .heard__RDY(heard__RDY),
    .busy(busy), .done(done), .err_count(err_count), .first_err(first_err)
`ifdef IVECTOR_INITIATOR_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  always #5 CLK = ~CLK;

  // Echo server: presents queue head on negedge, commits the posedge handshakes.
  always @(negedge CLK) begin
    logic acc, snd;
    logic [5:0] sm;
    logic [3:0] sv;
    heard__ENA = !hold && (q.size() > 0);
    if (q.size() > 0) begin
      heard_meth = q[0][9:4];
      heard_v    = q[0][3:0];
    end else begin
      heard_meth = '0;
      heard_v    = '0;
    end
    #1;
    acc = heard__ENA && heard__RDY;
    snd = say__ENA;
    sm  = say_meth;
    sv  = say_v;
    @(posedge CLK);
    if (RST) begin
      q.delete();
    end else begin
      if (acc) void'(q.pop_front());
      if (snd) begin
        log_m[snd_total] = sm;
        log_v[snd_total] = sv;
        q.push_back({sm, (snd_total == corrupt_at) ? (sv ^ 4'h8) : sv});
        snd_total++;
      end
    end
  end

  task automatic do_start(input logic [8:0] n);
    base  = snd_total;
    start = 1'b1;
    count = n;
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 600 && !done; k++) begin
      @(posedge CLK); #2;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout got=%b want=1", name, done);
    end
  endtask

  task automatic test_reset;
    @(posedge CLK); #2;
    checks++; if (say__ENA !== 1'b0) begin errors++; $display("FAIL rst_say_ena got=%b want=0", say__ENA); end
    checks++; if (say_meth !== 6'd0) begin errors++; $display("FAIL rst_say_meth got=%0d want=0", say_meth); end
    checks++; if (say_v !== 4'd0) begin errors++; $display("FAIL rst_say_v got=%0d want=0", say_v); end
    checks++; if (heard__RDY !== 1'b0) begin errors++; $display("FAIL rst_heard_rdy got=%b want=0", heard__RDY); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", done); end
    checks++; if (err_count !== 9'd0) begin errors++; $display("FAIL rst_err_count got=%0d want=0", err_count); end
    checks++; if (first_err !== 10'd0) begin errors++; $display("FAIL rst_first_err got=%h want=0", first_err); end
    RST = 1'b0;
  endtask

  task automatic test_echo;
    do_start(9'd5);
    wait_done("echo");
    checks++; if (snd_total - base != 5) begin errors++; $display("FAIL echo_sends got=%0d want=5", snd_total - base); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_m[base+i] !== 6'(i) || log_v[base+i] !== 4'(i)) begin
        errors++; $display("FAIL echo_req%0d got=(%0d,%0d) want=(%0d,%0d)", i, log_m[base+i], log_v[base+i], i, i);
      end
    end
    checks++; if (err_count !== 9'd0) begin errors++; $display("FAIL echo_err got=%0d want=0", err_count); end
    checks++; if (first_err !== 10'd0) begin errors++; $display("FAIL echo_first_err got=%h want=0", first_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL echo_busy got=%b want=0", busy); end
  endtask

  task automatic test_empty;
    do_start(9'd0);
    #1;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL empty_run got=busy%b,done%b want=busy1,done0", busy, done); end
    @(posedge CLK); #2;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_done got=%b want=1", done); end
    checks++; if (snd_total != base) begin errors++; $display("FAIL empty_sends got=%0d want=0", snd_total - base); end
  endtask

  task automatic test_backpressure;
    hold = 1'b1;
    do_start(9'd20);
    repeat (10) begin @(posedge CLK); #2; end
    checks++; if (snd_total - base != 4) begin errors++; $display("FAIL bp_held_sends got=%0d want=4", snd_total - base); end
    checks++; if (say__ENA !== 1'b0) begin errors++; $display("FAIL bp_say_ena got=%b want=0", say__ENA); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy got=%b want=1", busy); end
    hold = 1'b0;
    wait_done("backpressure");
    checks++; if (snd_total - base != 20) begin errors++; $display("FAIL bp_sends got=%0d want=20", snd_total - base); end
    checks++; if (err_count !== 9'd0) begin errors++; $display("FAIL bp_err got=%0d want=0", err_count); end
  endtask

  task automatic test_corrupt;
    corrupt_at = snd_total + 1;
    do_start(9'd3);
    wait_done("corrupt");
    corrupt_at = -1;
    checks++; if (err_count !== 9'd1) begin errors++; $display("FAIL corrupt_err got=%0d want=1", err_count); end
    checks++; if (first_err !== 10'h019) begin errors++; $display("FAIL corrupt_first_err got=%h want=019", first_err); end
  endtask

  task automatic test_wrap;
    do_start(9'd40);
    wait_done("wrap");
    checks++; if (snd_total - base != 40) begin errors++; $display("FAIL wrap_sends got=%0d want=40", snd_total - base); end
    checks++; if (log_v[base+15] !== 4'd15 || log_v[base+16] !== 4'd0) begin
      errors++; $display("FAIL wrap_v got=%0d,%0d want=15,0", log_v[base+15], log_v[base+16]); end
    checks++; if (log_m[base+16] !== 6'd16 || log_m[base+39] !== 6'd39) begin
      errors++; $display("FAIL wrap_meth got=%0d,%0d want=16,39", log_m[base+16], log_m[base+39]); end
    checks++; if (err_count !== 9'd0) begin errors++; $display("FAIL wrap_err got=%0d want=0", err_count); end
  endtask

  task automatic test_reset_midrun;
    do_start(9'd40);
    for (int k = 0; k < 100 && (snd_total - base) < 10; k++) begin
      @(posedge CLK); #2;
    end
    checks++; if (snd_total - base != 10) begin errors++; $display("FAIL mid_reach got=%0d want=10", snd_total - base); end
    RST = 1'b1;
    @(posedge CLK); #2;
    checks++; if (busy !== 1'b0 || heard__RDY !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_state got=busy%b,rdy%b,done%b want=0,0,0", busy, heard__RDY, done); end
    checks++; if (say__ENA !== 1'b0 || say_meth !== 6'd0 || say_v !== 4'd0) begin
      errors++; $display("FAIL mid_say got=ena%b,%0d,%0d want=0,0,0", say__ENA, say_meth, say_v); end
    checks++; if (err_count !== 9'd0 || first_err !== 10'd0) begin
      errors++; $display("FAIL mid_err got=%0d,%h want=0,0", err_count, first_err); end
    RST = 1'b0;
    @(posedge CLK); #2;
    do_start(9'd2);
    wait_done("post_reset");
    checks++; if (err_count !== 9'd0) begin errors++; $display("FAIL post_reset_err got=%0d want=0", err_count); end
  endtask

`ifdef IVECTOR_INITIATOR_TIMEOUT_EN
  task automatic test_timeout;
    say__RDY = 1'b0;
    do_start(9'd3);
    for (int k = 0; k < 4300 && !done; k++) begin
      @(posedge CLK); #2;
    end
    checks++; if (timeout !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL timeout got=to%b,done%b want=1,1", timeout, done); end
    say__RDY = 1'b1;
  endtask
`endif

  initial begin
    RST = 1'b1; start = 1'b0; count = '0; say__RDY = 1'b1;
    repeat (2) @(posedge CLK);
    test_reset;
    test_echo;
    test_empty;
    test_backpressure;
    test_corrupt;
    test_wrap;
    test_reset_midrun;
`ifdef IVECTOR_INITIATOR_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
